// File: rtl/dbchecker_pkg.sv
// dbchecker_pkg: AXI burst/resp encodings and read-splitter FSM states
package dbchecker_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} rd_split_state_t;
endpackage

// File: rtl/dma_rd_split_calc.sv
// dma_rd_split_calc: beats of the next sub-burst and the aligned address after it
module dma_rd_split_calc #(
  parameter int ADDR_W         = 32,
  parameter int BOUNDARY_LOG2  = 12,
  parameter int MAX_BEATS_LOG2 = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [8:0]        beats_left_i,
  output logic [8:0]        beats_o,
  output logic [ADDR_W-1:0] next_addr_o
);
  localparam int unsigned CAP = 1 << MAX_BEATS_LOG2;
  logic [ADDR_W-1:0] aligned;
  logic [31:0]       to_bnd;
  logic [8:0]        lim;
  // clamp remaining beats to the boundary distance and the per-burst cap
  always_comb begin
    aligned     = addr_i & ~((ADDR_W'(1) << size_i) - ADDR_W'(1));
    to_bnd      = ((32'd1 << BOUNDARY_LOG2) - 32'(aligned[BOUNDARY_LOG2-1:0])) >> size_i;
    lim         = to_bnd > 32'(CAP) ? 9'(CAP) : 9'(to_bnd);
    beats_o     = beats_left_i < lim ? beats_left_i : lim;
    next_addr_o = aligned + (ADDR_W'(beats_o) << size_i);
  end
endmodule

// File: rtl/dma_rd_splitter.sv
// dma_rd_splitter: splits INCR read bursts at boundaries, regenerates rlast (DMA_RD_SPLIT_STAT_EN adds split_count)
module dma_rd_splitter
  import dbchecker_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 128,
  parameter int BOUNDARY_LOG2  = 12,
  parameter int MAX_BEATS_LOG2 = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic [3:0]        s_axi_arcache,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
`ifdef DMA_RD_SPLIT_STAT_EN
  ,
  output logic [31:0]       split_count
`endif
);
  rd_split_state_t   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, m_addr_q, m_addr_d, calc_addr, next_addr;
  logic [8:0]        beats_q, beats_d, r_left_q, r_left_d, r_left_dec, beats_rem, calc_beats, sub_beats;
  logic [7:0]        m_len_q, m_len_d;
  logic [2:0]        size_q, size_d, prot_q, prot_d, calc_size;
  logic [1:0]        burst_q, burst_d;
  logic [3:0]        cache_q, cache_d;
  logic              m_valid_q, m_valid_d, first_q, first_d;
  logic              idle, ar_hs, m_hs, r_hs, unused_rlast;

  assign idle          = state_q == ST_IDLE;
  assign s_axi_arready = idle;
  assign ar_hs         = s_axi_arvalid && idle;
  assign m_hs          = m_valid_q && m_axi_arready;
  assign r_hs          = m_axi_rvalid && s_axi_rready;
  assign m_axi_araddr  = m_addr_q;
  assign m_axi_arlen   = m_len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;
  assign m_axi_arcache = cache_q;
  assign m_axi_arprot  = prot_q;
  assign m_axi_arvalid = m_valid_q;
  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rvalid && r_left_q == 9'd1;
  assign unused_rlast  = m_axi_rlast;
  assign beats_rem     = beats_q - (9'(m_len_q) + 9'd1);
  assign r_left_dec    = r_left_q - 9'(r_hs && r_left_q != 9'd0);
  assign calc_addr     = idle ? s_axi_araddr : addr_q;
  assign calc_size     = idle ? s_axi_arsize : size_q;
  assign calc_beats    = idle ? 9'(s_axi_arlen) + 9'd1 : beats_rem;

  dma_rd_split_calc #(
    .ADDR_W(ADDR_W), .BOUNDARY_LOG2(BOUNDARY_LOG2), .MAX_BEATS_LOG2(MAX_BEATS_LOG2)
  ) u_calc (
    .addr_i(calc_addr), .size_i(calc_size), .beats_left_i(calc_beats),
    .beats_o(sub_beats), .next_addr_o(next_addr)
  );

  // state and registered AR outputs; mid-burst reset drops everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      m_addr_q  <= '0;
      beats_q   <= '0;
      r_left_q  <= '0;
      m_len_q   <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cache_q   <= '0;
      prot_q    <= '0;
      m_valid_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      m_addr_q  <= m_addr_d;
      beats_q   <= beats_d;
      r_left_q  <= r_left_d;
      m_len_q   <= m_len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cache_q   <= cache_d;
      prot_q    <= prot_d;
      m_valid_q <= m_valid_d;
      first_q   <= first_d;
    end
  end

  // accept a burst, issue sub-bursts back-to-back, then wait for the R beats to drain
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    m_addr_d  = m_addr_q;
    beats_d   = beats_q;
    r_left_d  = r_left_q;
    m_len_d   = m_len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cache_d   = cache_q;
    prot_d    = prot_q;
    m_valid_d = m_valid_q;
    first_d   = first_q;
    case (state_q)
      ST_IDLE: if (ar_hs) begin
        state_d   = ST_ISSUE;
        size_d    = s_axi_arsize;
        burst_d   = s_axi_arburst;
        cache_d   = s_axi_arcache;
        prot_d    = s_axi_arprot;
        beats_d   = calc_beats;
        r_left_d  = calc_beats;
        m_addr_d  = s_axi_araddr;
        m_len_d   = s_axi_arburst == BURST_INCR ? 8'(sub_beats - 9'd1) : s_axi_arlen;
        addr_d    = next_addr;
        m_valid_d = 1'b1;
        first_d   = 1'b1;
      end
      ST_ISSUE: begin
        r_left_d = r_left_dec;
        if (m_hs) begin
          beats_d   = beats_rem;
          first_d   = 1'b0;
          m_valid_d = beats_rem != 9'd0;
          m_addr_d  = beats_rem != 9'd0 ? addr_q : m_addr_q;
          m_len_d   = beats_rem != 9'd0 ? 8'(sub_beats - 9'd1) : m_len_q;
          addr_d    = beats_rem != 9'd0 ? next_addr : addr_q;
          state_d   = beats_rem != 9'd0 ? ST_ISSUE : r_left_dec == 9'd0 ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        r_left_d = r_left_dec;
        state_d  = r_left_dec == 9'd0 ? ST_IDLE : ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DMA_RD_SPLIT_STAT_EN
  logic [31:0] split_q;
  // saturating count of sub-bursts issued after the first of each upstream burst
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) split_q <= '0;
    else if (m_hs && !first_q && split_q != '1) split_q <= split_q + 32'd1;
  end
  assign split_count = split_q;
`else
  logic unused_first;
  assign unused_first = first_q;
`endif
endmodule

// File: tb/tb_dma_rd_splitter.sv
// tb_dma_rd_splitter: directed vector bench for dma_rd_splitter (honours DMA_RD_SPLIT_STAT_EN)
module tb_dma_rd_splitter;
  import dbchecker_pkg::*;
  logic         clock = 0, reset = 0;
  logic [31:0]  s_axi_araddr = 0, m_axi_araddr;
  logic [7:0]   s_axi_arlen = 0, m_axi_arlen;
  logic [2:0]   s_axi_arsize = 0, m_axi_arsize, s_axi_arprot = 0, m_axi_arprot;
  logic [1:0]   s_axi_arburst = 0, m_axi_arburst, s_axi_rresp, m_axi_rresp = 0;
  logic [3:0]   s_axi_arcache = 0, m_axi_arcache;
  logic         s_axi_arvalid = 0, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready = 1;
  logic         m_axi_arvalid, m_axi_arready = 0, m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;
  logic [127:0] s_axi_rdata, m_axi_rdata = 0;
`ifdef DMA_RD_SPLIT_STAT_EN
  logic [31:0]  split_count;
`endif

  always #5 clock = ~clock;

  dma_rd_splitter dut (
    .clock(clock), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef DMA_RD_SPLIT_STAT_EN
    , .split_count(split_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          stall;
    bit          inject;
    int          exp_n;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
  } vec_t;

  vec_t        vecs[11];
  int          total = 0, bad = 0;
  logic [31:0] ga[$];
  logic [7:0]  gl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    int          sent, n, stall, cyc, early, unstable, attr, rd_err, rl_err;
    bit          ar_done, prev_stall;
    logic [52:0] prev, cur;
    logic [3:0]  cache;
    logic [2:0]  prot;
`ifdef DMA_RD_SPLIT_STAT_EN
    logic [31:0] sc0;
    sc0 = split_count;
`endif
    sent = 0; n = int'(v.len) + 1; stall = v.stall; cyc = 0;
    early = 0; unstable = 0; attr = 0; rd_err = 0; rl_err = 0;
    ar_done = 0; prev_stall = 0; prev = '0;
    cache = 4'(id + 3); prot = 3'(id);
    ga.delete(); gl.delete();
    @(negedge clock);
    s_axi_araddr = v.addr; s_axi_arlen = v.len; s_axi_arsize = v.size; s_axi_arburst = v.burst;
    s_axi_arcache = cache; s_axi_arprot = prot; s_axi_arvalid = 1;
    m_axi_arready = 0; m_axi_rvalid = 0;
    #1 chk($sformatf("v%0d arready_idle", id), 64'(s_axi_arready), 1);
    @(negedge clock);
    s_axi_arvalid = 0;
    while (sent < n && cyc < 1000) begin
      m_axi_arready = stall == 0;
      if (stall > 0) stall--;
      m_axi_rvalid = ar_done || v.inject;
      m_axi_rdata  = 128'(sent * 7 + id);
      m_axi_rresp  = 2'(sent);
      #1;
      if (cyc == 0) chk($sformatf("v%0d arvalid_n1", id), 64'(m_axi_arvalid), 1);
      if (s_axi_arready) early++;
      cur = {m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot};
      if (prev_stall && cur !== prev) unstable++;
      prev_stall = m_axi_arvalid && !m_axi_arready;
      prev = cur;
      if (m_axi_arvalid && m_axi_arready) begin
        ga.push_back(m_axi_araddr);
        gl.push_back(m_axi_arlen);
        if (m_axi_arsize !== v.size || m_axi_arburst !== v.burst || m_axi_arcache !== cache || m_axi_arprot !== prot) attr++;
      end
      if (!m_axi_arvalid) ar_done = 1;
      if (s_axi_rvalid !== m_axi_rvalid || m_axi_rready !== s_axi_rready) rd_err++;
      if (m_axi_rvalid) begin
        if (s_axi_rdata !== m_axi_rdata || s_axi_rresp !== m_axi_rresp) rd_err++;
        if (s_axi_rlast !== (sent == n - 1)) rl_err++;
        sent++;
      end else if (s_axi_rlast !== 1'b0) rl_err++;
      cyc++;
      @(negedge clock);
    end
    m_axi_rvalid = 0; m_axi_arready = 0;
    #1;
    chk($sformatf("v%0d beats_done", id), 64'(sent), 64'(n));
    chk($sformatf("v%0d arready_after", id), 64'(s_axi_arready), 1);
    chk($sformatf("v%0d arvalid_after", id), 64'(m_axi_arvalid), 0);
    chk($sformatf("v%0d n_ar", id), 64'(ga.size()), 64'(v.exp_n));
    if (ga.size() > 0) begin
      chk($sformatf("v%0d ar0_addr", id), 64'(ga[0]), 64'(v.a0));
      chk($sformatf("v%0d ar0_len", id), 64'(gl[0]), 64'(v.l0));
    end
    if (v.exp_n > 1 && ga.size() > 1) begin
      chk($sformatf("v%0d ar1_addr", id), 64'(ga[1]), 64'(v.a1));
      chk($sformatf("v%0d ar1_len", id), 64'(gl[1]), 64'(v.l1));
    end
    chk($sformatf("v%0d ar_attr_errs", id), 64'(attr), 0);
    chk($sformatf("v%0d arready_early", id), 64'(early), 0);
    chk($sformatf("v%0d ar_unstable", id), 64'(unstable), 0);
    chk($sformatf("v%0d r_pass_errs", id), 64'(rd_err), 0);
    chk($sformatf("v%0d rlast_errs", id), 64'(rl_err), 0);
`ifdef DMA_RD_SPLIT_STAT_EN
    chk($sformatf("v%0d split_delta", id), 64'(split_count - sc0), 64'(v.exp_n - 1));
`endif
  endtask

  initial begin
    vecs[0]  = '{32'h0FC0, 8'd7,   3'd4, BURST_INCR,  0, 1'b0, 2, 32'h0FC0, 8'd3,   32'h1000, 8'd3};
    vecs[1]  = '{32'h0000, 8'd255, 3'd4, BURST_INCR,  0, 1'b0, 1, 32'h0000, 8'd255, 32'h0,    8'd0};
    vecs[2]  = '{32'h0010, 8'd255, 3'd4, BURST_INCR,  0, 1'b0, 2, 32'h0010, 8'd254, 32'h1000, 8'd0};
    vecs[3]  = '{32'h0FF0, 8'd15,  3'd4, BURST_FIXED, 0, 1'b0, 1, 32'h0FF0, 8'd15,  32'h0,    8'd0};
    vecs[4]  = '{32'h0FC0, 8'd7,   3'd4, BURST_INCR,  5, 1'b1, 2, 32'h0FC0, 8'd3,   32'h1000, 8'd3};
    vecs[5]  = '{32'h0FC4, 8'd7,   3'd4, BURST_INCR,  0, 1'b0, 2, 32'h0FC4, 8'd3,   32'h1000, 8'd3};
    vecs[6]  = '{32'h0F00, 8'd255, 3'd2, BURST_INCR,  0, 1'b0, 2, 32'h0F00, 8'd63,  32'h1000, 8'd191};
    vecs[7]  = '{32'h0FFF, 8'd255, 3'd0, BURST_INCR,  0, 1'b0, 2, 32'h0FFF, 8'd0,   32'h1000, 8'd254};
    vecs[8]  = '{32'h0FF0, 8'd3,   3'd4, BURST_WRAP,  0, 1'b0, 1, 32'h0FF0, 8'd3,   32'h0,    8'd0};
    vecs[9]  = '{32'h0FF0, 8'd7,   3'd4, 2'b11,       0, 1'b0, 1, 32'h0FF0, 8'd7,   32'h0,    8'd0};
    vecs[10] = '{32'h0010, 8'd255, 3'd4, BURST_INCR,  2, 1'b0, 2, 32'h0010, 8'd254, 32'h1000, 8'd0};
    repeat (3) @(negedge clock);
    #1;
    chk("reset arready", 64'(s_axi_arready), 1);
    chk("reset arvalid", 64'(m_axi_arvalid), 0);
    chk("reset araddr", 64'(m_axi_araddr), 0);
    chk("reset arlen", 64'(m_axi_arlen), 0);
`ifdef DMA_RD_SPLIT_STAT_EN
    chk("reset split_count", 64'(split_count), 0);
`endif
    reset = 1;
    for (int i = 0; i < 10; i++) run(vecs[i], i);
    @(negedge clock);
    s_axi_araddr = 32'h0FC0; s_axi_arlen = 8'd7; s_axi_arsize = 3'd4; s_axi_arburst = BURST_INCR;
    s_axi_arcache = 4'h0; s_axi_arprot = 3'h0; s_axi_arvalid = 1; m_axi_arready = 1;
    @(negedge clock);
    s_axi_arvalid = 0;
    #1;
    chk("mid_rst ar0_valid", 64'(m_axi_arvalid), 1);
    chk("mid_rst ar0_addr", 64'(m_axi_araddr), 64'h0FC0);
    @(negedge clock);
    #1;
    chk("mid_rst ar1_addr", 64'(m_axi_araddr), 64'h1000);
    reset = 0; m_axi_arready = 0;
    @(negedge clock);
    #1;
    chk("mid_rst arvalid", 64'(m_axi_arvalid), 0);
    chk("mid_rst arready", 64'(s_axi_arready), 1);
    chk("mid_rst araddr", 64'(m_axi_araddr), 0);
`ifdef DMA_RD_SPLIT_STAT_EN
    chk("mid_rst split_count", 64'(split_count), 0);
`endif
    reset = 1;
    run(vecs[10], 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
